lp805x_schedfs_ctrl: RTL and testbench



---
 rtl/lp805x_schedfs_ctrl.sv | 101 ++++++++++
 tb/tb_lp805x_schedfs_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lp805x_schedfs_ctrl.sv
// Frequency-scaling factor controller for lp805x_schedfs: arbitrates CPU vs idle
// targets and ramps the factor in bounded steps, only at scheduler period boundaries.
module lp805x_schedfs_ctrl #(
   parameter int            DW           = 8,
   parameter logic [DW-1:0] RESET_FACTOR = {DW{1'b0}},
   parameter logic [DW-1:0] IDLE_FACTOR  = {DW{1'b1}},
   parameter logic [DW-1:0] STEP         = {{(DW-1){1'b0}}, 1'b1}
) (
   input  logic          clki,
   input  logic          rst_n,
   input  logic          cpu_wr,
   input  logic [DW-1:0] cpu_factor,
   input  logic          idle_req,
   input  logic [DW-1:0] index_i,
   output logic [DW-1:0] factor_o,
   output logic          busy,
   output logic          done,
   output logic          src_idle
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SYNC,
      ST_STEP,
      ST_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] factor_q, factor_d;
   logic [DW-1:0] cpuTgt_q, cpuTgt_d;
   logic          srcIdle_q;

   logic [DW-1:0] effTgt;
   logic          stepUp;
   logic [DW-1:0] stepDelta;
   logic [DW-1:0] stepSize;
   logic [DW-1:0] stepped;

   assign effTgt = idle_req ? IDLE_FACTOR : cpuTgt_q;

   // Clamp the step to the remaining distance so the factor can never overshoot or wrap.
   always_comb begin
      stepUp    = (effTgt > factor_q);
      stepDelta = stepUp ? (effTgt - factor_q) : (factor_q - effTgt);
      stepSize  = (stepDelta < STEP) ? stepDelta : STEP;
      stepped   = stepUp ? (factor_q + stepSize) : (factor_q - stepSize);
   end

   always_comb begin
      cpuTgt_d = cpu_wr ? cpu_factor : cpuTgt_q;
   end

   always_comb begin
      state_d  = state_q;
      factor_d = factor_q;
      unique case (state_q)
         ST_IDLE: begin
            if (effTgt != factor_q) begin
               state_d = ST_SYNC;
            end
         end
         ST_SYNC: begin
            if (effTgt == factor_q) begin
               state_d = ST_DONE;
            end else if (index_i == '0) begin
               state_d = ST_STEP;
            end
         end
         ST_STEP: begin
            factor_d = stepped;
            state_d  = (stepped == effTgt) ? ST_DONE : ST_SYNC;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clki or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         factor_q  <= RESET_FACTOR;
         cpuTgt_q  <= RESET_FACTOR;
         srcIdle_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         factor_q  <= factor_d;
         cpuTgt_q  <= cpuTgt_d;
         srcIdle_q <= idle_req;
      end
   end

   assign factor_o = factor_q;
   assign busy     = (state_q == ST_SYNC) || (state_q == ST_STEP);
   assign done     = (state_q == ST_DONE);
   assign src_idle = srcIdle_q;

endmodule

// File: tb/tb_lp805x_schedfs_ctrl.sv
// Scoreboard bench for lp805x_schedfs_ctrl: three instances with different STEP values,
// expected factor sequences queued per ramp and popped whenever the watched factor moves.
module tb_lp805x_schedfs_ctrl;

   logic       clki;
   logic       rst_n;
   logic       cpu_wr;
   logic [7:0] cpu_factor;
   logic       idle_req;
   logic [7:0] index_i;

   logic [7:0] factor [3];
   logic       busy   [3];
   logic       done   [3];
   logic       srcIdle[3];

   int         checkCount = 0;
   int         errorCount = 0;
   int         doneCount  = 0;
   int         monSel     = 0;
   logic [7:0] lastF      = 8'h00;
   logic [7:0] expQ[$];

   lp805x_schedfs_ctrl #(.DW(8), .RESET_FACTOR(8'h00), .IDLE_FACTOR(8'hFF), .STEP(8'h01)) u_step1 (
      .clki(clki), .rst_n(rst_n), .cpu_wr(cpu_wr), .cpu_factor(cpu_factor),
      .idle_req(idle_req), .index_i(index_i), .factor_o(factor[0]),
      .busy(busy[0]), .done(done[0]), .src_idle(srcIdle[0]));

   lp805x_schedfs_ctrl #(.DW(8), .RESET_FACTOR(8'h00), .IDLE_FACTOR(8'hFF), .STEP(8'h03)) u_step3 (
      .clki(clki), .rst_n(rst_n), .cpu_wr(cpu_wr), .cpu_factor(cpu_factor),
      .idle_req(idle_req), .index_i(index_i), .factor_o(factor[1]),
      .busy(busy[1]), .done(done[1]), .src_idle(srcIdle[1]));

   lp805x_schedfs_ctrl #(.DW(8), .RESET_FACTOR(8'h00), .IDLE_FACTOR(8'hFF), .STEP(8'h80)) u_step80 (
      .clki(clki), .rst_n(rst_n), .cpu_wr(cpu_wr), .cpu_factor(cpu_factor),
      .idle_req(idle_req), .index_i(index_i), .factor_o(factor[2]),
      .busy(busy[2]), .done(done[2]), .src_idle(srcIdle[2]));

   initial begin
      clki = 1'b0;
      forever #5 clki = ~clki;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Every movement of the watched factor must match the next queued value.
   always @(negedge clki) begin
      if (!rst_n) begin
         lastF = factor[monSel];
      end else begin
         checkOutput("busyDoneExcl", {31'b0, busy[monSel] & done[monSel]}, 32'd0);
         if (done[monSel]) doneCount++;
         if (factor[monSel] !== lastF) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedStep", {24'b0, factor[monSel]}, {24'b0, lastF});
            end else begin
               checkOutput("factorSeq", {24'b0, factor[monSel]}, {24'b0, expQ.pop_front()});
            end
            lastF = factor[monSel];
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] f);
      @(posedge clki);
      #1;
      cpu_wr     = 1'b1;
      cpu_factor = f;
      @(posedge clki);
      #1;
      cpu_wr     = 1'b0;
   endtask

   task automatic doReset(input int sel);
      rst_n    = 1'b0;
      cpu_wr   = 1'b0;
      idle_req = 1'b0;
      index_i  = 8'h00;
      repeat (2) @(negedge clki);
      monSel    = sel;
      expQ.delete();
      doneCount = 0;
      @(negedge clki);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic waitIdle(input int maxCycles);
      bit reached;
      reached = 1'b0;
      for (int n = 0; n < maxCycles && !reached; n++) begin
         @(negedge clki);
         #1;
         if (expQ.size() == 0 && !busy[monSel] && !done[monSel]) reached = 1'b1;
      end
      if (!reached) checkOutput("waitIdleTimeout", 32'd0, 32'd1);
      repeat (4) @(negedge clki);
      #1;
   endtask

   initial begin
      bit hit;
      rst_n      = 1'b0;
      cpu_wr     = 1'b1;
      cpu_factor = 8'h55;
      idle_req   = 1'b1;
      index_i    = 8'h00;

      // Reset hold with active inputs: everything must stay at reset values.
      repeat (4) @(negedge clki);
      checkOutput("rstFactor0", {24'b0, factor[0]}, 32'h00);
      checkOutput("rstFactor2", {24'b0, factor[2]}, 32'h00);
      checkOutput("rstBusy", {31'b0, busy[0]}, 32'd0);
      checkOutput("rstDone", {31'b0, done[0]}, 32'd0);
      checkOutput("rstSrcIdle", {31'b0, srcIdle[0]}, 32'd0);

      // CPU ramp 00 -> 03 with STEP=1, plus first-write latency.
      doReset(0);
      expQ.push_back(8'h01);
      expQ.push_back(8'h02);
      expQ.push_back(8'h03);
      applyStimulus(8'h03);
      @(negedge clki);
      checkOutput("latC0Busy", {31'b0, busy[0]}, 32'd0);
      @(negedge clki);
      checkOutput("latC1Busy", {31'b0, busy[0]}, 32'd1);
      @(negedge clki);
      checkOutput("latC2Factor", {24'b0, factor[0]}, 32'h00);
      @(negedge clki);
      checkOutput("latC3Factor", {24'b0, factor[0]}, 32'h01);
      checkOutput("latC3Done", {31'b0, done[0]}, 32'd0);
      waitIdle(60);
      checkOutput("cpuFinal", {24'b0, factor[0]}, 32'h03);
      checkOutput("cpuDoneCount", doneCount, 32'd1);
      checkOutput("cpuBusyAfter", {31'b0, busy[0]}, 32'd0);

      // Boundary gating: no step while index_i != 0.
      doReset(0);
      index_i = 8'h07;
      for (int v = 1; v <= 5; v++) expQ.push_back(8'(v));
      applyStimulus(8'h05);
      repeat (20) @(negedge clki);
      checkOutput("gateFactor", {24'b0, factor[0]}, 32'h00);
      checkOutput("gateBusy", {31'b0, busy[0]}, 32'd1);
      @(posedge clki);
      #1;
      index_i = 8'h00;
      @(negedge clki);
      @(negedge clki);
      checkOutput("gateRelease1", {24'b0, factor[0]}, 32'h00);
      @(negedge clki);
      checkOutput("gateRelease2", {24'b0, factor[0]}, 32'h01);
      waitIdle(60);
      checkOutput("gateFinal", {24'b0, factor[0]}, 32'h05);
      checkOutput("gateDoneCount", doneCount, 32'd1);

      // Idle override with STEP=0x80.
      doReset(2);
      expQ.push_back(8'h04);
      applyStimulus(8'h04);
      waitIdle(40);
      checkOutput("idlePre", {24'b0, factor[2]}, 32'h04);
      expQ.push_back(8'h84);
      expQ.push_back(8'hFF);
      @(posedge clki);
      #1;
      idle_req = 1'b1;
      @(negedge clki);
      @(negedge clki);
      checkOutput("srcIdleHigh", {31'b0, srcIdle[2]}, 32'd1);
      waitIdle(40);
      checkOutput("idleTop", {24'b0, factor[2]}, 32'hFF);
      checkOutput("idleDoneCount", doneCount, 32'd2);
      expQ.push_back(8'h7F);
      expQ.push_back(8'h04);
      @(posedge clki);
      #1;
      idle_req = 1'b0;
      waitIdle(40);
      checkOutput("srcIdleLow", {31'b0, srcIdle[2]}, 32'd0);
      checkOutput("idleBack", {24'b0, factor[2]}, 32'h04);
      checkOutput("idleBackDone", doneCount, 32'd3);

      // cpu_wr together with idle_req rising: idle wins, CPU target remembered.
      doReset(2);
      expQ.push_back(8'h80);
      expQ.push_back(8'hFF);
      @(posedge clki);
      #1;
      cpu_wr     = 1'b1;
      cpu_factor = 8'h10;
      idle_req   = 1'b1;
      @(posedge clki);
      #1;
      cpu_wr = 1'b0;
      waitIdle(40);
      checkOutput("simulTop", {24'b0, factor[2]}, 32'hFF);
      expQ.push_back(8'h7F);
      expQ.push_back(8'h10);
      idle_req = 1'b0;
      waitIdle(40);
      checkOutput("simulFinal", {24'b0, factor[2]}, 32'h10);
      checkOutput("simulDone", doneCount, 32'd2);

      // Reversal: STEP=3 toward 0A, redirected to 02 at 06.
      doReset(1);
      expQ.push_back(8'h03);
      expQ.push_back(8'h06);
      expQ.push_back(8'h03);
      expQ.push_back(8'h02);
      applyStimulus(8'h0A);
      hit = 1'b0;
      for (int n = 0; n < 50 && !hit; n++) begin
         @(negedge clki);
         if (factor[1] == 8'h06) hit = 1'b1;
      end
      checkOutput("revReach06", {31'b0, hit}, 32'd1);
      cpu_wr     = 1'b1;
      cpu_factor = 8'h02;
      @(posedge clki);
      #1;
      cpu_wr = 1'b0;
      waitIdle(40);
      checkOutput("revFinal", {24'b0, factor[1]}, 32'h02);
      checkOutput("revDoneCount", doneCount, 32'd1);

      // Asynchronous reset in the middle of a ramp.
      doReset(1);
      expQ.push_back(8'h03);
      expQ.push_back(8'h06);
      applyStimulus(8'h0A);
      hit = 1'b0;
      for (int n = 0; n < 50 && !hit; n++) begin
         @(negedge clki);
         if (factor[1] == 8'h06) hit = 1'b1;
      end
      checkOutput("midReach06", {31'b0, hit}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncFactor", {24'b0, factor[1]}, 32'h00);
      checkOutput("asyncBusy", {31'b0, busy[1]}, 32'd0);
      checkOutput("asyncDone", {31'b0, done[1]}, 32'd0);
      checkOutput("asyncQueue", expQ.size(), 32'd0);
      @(negedge clki);
      #1;
      rst_n = 1'b1;
      repeat (5) @(negedge clki);
      checkOutput("postRstFactor", {24'b0, factor[1]}, 32'h00);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
